mips_decode_queue: RTL and testbench

//  Registered, queued successor to the combinational mips_decode.
//  - Accepts 32-bit MIPS instructions over a valid/ready handshake.
//  - Decodes each accepted instruction into ALU control plus register and immediate fields.
//  - Buffers decoded entries in a DEPTH-entry FIFO that feeds the execute stage.
//  - Tracks a sticky exception flag; can optionally stall the front end on an exception.

---
 rtl/mips_decode_queue.sv | 190 +++++++++++++++++++
 tb/tb_mips_decode_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips_decode_queue
// Purpose  : Registered, queued MIPS decoder. Instructions arrive over a
//            valid/ready handshake, are decoded at acceptance into ALU
//            control plus register/immediate fields, and are buffered in a
//            DEPTH-entry FIFO that feeds the execute stage. A sticky
//            exception flag records any accepted illegal instruction and,
//            with HALT_ON_EXC=1, stalls the front end until cleared.
// Ports    : clock_i / reset_n_i      clock, async active-low reset
//            in_valid_i / in_ready_o  input handshake, in_inst_i 32-bit word
//            out_valid_o / out_ready_i head-of-queue handshake
//            out_alu_op_o, out_alu_src2_o, out_rd_src_o, out_writeenable_o,
//            out_except_o, out_rs_o, out_rt_o, out_rd_o, out_imm_o
//                                     decoded head entry (0 when not valid)
//            count_o                  FIFO occupancy
//            exc_pending_o / exc_clear_i sticky exception flag and its clear
//            stat_decoded_o / stat_except_o  saturating counters, present
//                                     only when DECODE_STATS_EN is defined
// Config   : DECODE_STATS_EN (macro) enables the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module mips_decode_queue #(
    parameter int DEPTH       = 4,
    parameter bit HALT_ON_EXC = 1'b1
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_inst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [2:0]                 out_alu_op_o,
    output logic [1:0]                 out_alu_src2_o,
    output logic                       out_rd_src_o,
    output logic                       out_writeenable_o,
    output logic                       out_except_o,
    output logic [4:0]                 out_rs_o,
    output logic [4:0]                 out_rt_o,
    output logic [4:0]                 out_rd_o,
    output logic [15:0]                out_imm_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       exc_pending_o,
    input  logic                       exc_clear_i
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]                stat_decoded_o,
    output logic [15:0]                stat_except_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Register/immediate fields are kept as the raw low 26 instruction bits;
    // rs/rt/rd/imm are sliced from them on the way out.
    typedef struct packed {
        logic [2:0]  alu_op;
        logic [1:0]  src2;
        logic        rd_src;
        logic        we;
        logic        except;
        logic [25:0] fields;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            exc_pending_q, exc_pending_d;
    logic            push, pop, full, halted;

    // ------------------------------------------------------------------
    // Decode of the incoming word
    // ------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        dec.fields = in_inst_i[25:0];
        dec.we     = 1'b1;
        unique case (in_inst_i[31:26])
            6'h00: begin
                case (in_inst_i[5:0])
                    6'h20:   dec.alu_op = 3'd2;
                    6'h22:   dec.alu_op = 3'd3;
                    6'h24:   dec.alu_op = 3'd4;
                    6'h25:   dec.alu_op = 3'd5;
                    6'h27:   dec.alu_op = 3'd6;
                    6'h26:   dec.alu_op = 3'd7;
                    default: begin
                        dec.except = 1'b1;
                        dec.we     = 1'b0;
                    end
                endcase
            end
            6'h08: begin dec.alu_op = 3'd2; dec.src2 = 2'd1; dec.rd_src = 1'b1; end
            6'h0c: begin dec.alu_op = 3'd4; dec.src2 = 2'd2; dec.rd_src = 1'b1; end
            6'h0d: begin dec.alu_op = 3'd5; dec.src2 = 2'd2; dec.rd_src = 1'b1; end
            6'h0e: begin dec.alu_op = 3'd7; dec.src2 = 2'd2; dec.rd_src = 1'b1; end
            default: begin
                dec.except = 1'b1;
                dec.we     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and FIFO bookkeeping
    // ------------------------------------------------------------------
    assign full        = (count_q == CW'(DEPTH));
    assign halted      = HALT_ON_EXC && exc_pending_q;
    // Full blocks a push even if the head leaves this same cycle.
    assign in_ready_o  = !full && !halted;
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        // DEPTH is a power of two, so pointer wrap is natural overflow.
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        // A newly accepted exception takes priority over a clear.
        if (push && dec.except)
            exc_pending_d = 1'b1;
        else if (exc_clear_i)
            exc_pending_d = 1'b0;
        else
            exc_pending_d = exc_pending_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            exc_pending_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            exc_pending_q <= exc_pending_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clock_i) begin
        if (push)
            mem_q[wr_ptr_q] <= dec;
    end

    // ------------------------------------------------------------------
    // Head presentation, masked to zero when the queue is empty
    // ------------------------------------------------------------------
    assign head              = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign out_alu_op_o      = head.alu_op;
    assign out_alu_src2_o    = head.src2;
    assign out_rd_src_o      = head.rd_src;
    assign out_writeenable_o = head.we;
    assign out_except_o      = head.except;
    assign out_rs_o          = head.fields[25:21];
    assign out_rt_o          = head.fields[20:16];
    assign out_rd_o          = head.fields[15:11];
    assign out_imm_o         = head.fields[15:0];
    assign count_o           = count_q;
    assign exc_pending_o     = exc_pending_q;

`ifdef DECODE_STATS_EN
    logic [15:0] stat_decoded_q, stat_except_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_decoded_q <= '0;
            stat_except_q  <= '0;
        end else begin
            if (push && (stat_decoded_q != 16'hFFFF))
                stat_decoded_q <= stat_decoded_q + 16'd1;
            if (push && dec.except && (stat_except_q != 16'hFFFF))
                stat_except_q <= stat_except_q + 16'd1;
        end
    end

    assign stat_decoded_o = stat_decoded_q;
    assign stat_except_o  = stat_except_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_decode_queue
// Purpose  : Directed self-checking bench for mips_decode_queue (DEPTH=4,
//            HALT_ON_EXC=1). Stimulus is a linear sequence of steps with
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_decode_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_alu_op;
    logic [1:0]  out_alu_src2;
    logic        out_rd_src;
    logic        out_we;
    logic        out_except;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [15:0] out_imm;
    logic [2:0]  count;
    logic        exc_pending;
    logic        exc_clear;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_decoded, stat_except;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_decode_queue #(.DEPTH(4), .HALT_ON_EXC(1'b1)) dut (
        .clock_i           (clk),
        .reset_n_i         (reset_n),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_inst_i         (in_inst),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_alu_op_o      (out_alu_op),
        .out_alu_src2_o    (out_alu_src2),
        .out_rd_src_o      (out_rd_src),
        .out_writeenable_o (out_we),
        .out_except_o      (out_except),
        .out_rs_o          (out_rs),
        .out_rt_o          (out_rt),
        .out_rd_o          (out_rd),
        .out_imm_o         (out_imm),
        .count_o           (count),
        .exc_pending_o     (exc_pending),
        .exc_clear_i       (exc_clear)
`ifdef DECODE_STATS_EN
        ,
        .stat_decoded_o    (stat_decoded),
        .stat_except_o     (stat_except)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0]  imm_op  [4] = '{6'h08, 6'h0c, 6'h0d, 6'h0e};
    logic [2:0]  imm_alu [4] = '{3'd2, 3'd4, 3'd5, 3'd7};
    logic [1:0]  imm_src [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    logic [15:0] imm_val [4] = '{16'hFFFC, 16'h00F0, 16'h1234, 16'hABCD};
    logic [4:0]  model_q [$];
    logic [4:0]  next_rd;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        out_ready = 1'b0;
        exc_clear = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // ---- reset state ----
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exc_pending", 32'(exc_pending), 32'd0);
        chk("rst_fields", {out_alu_op, out_alu_src2, out_rd_src, out_we, out_except,
                           out_rs, out_rt, out_rd}, 32'd0);
        chk("rst_imm", 32'(out_imm), 32'd0);

        // ---- R-type add then sub, no consumer ----
        in_valid = 1'b1;
        in_inst  = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        #1;
        chk("no_bypass_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        in_inst = mk_r(5'd4, 5'd5, 5'd6, 6'h22);
        step();
        in_valid = 1'b0;
        chk("rtype_count", 32'(count), 32'd2);
        chk("add_ctrl", {out_alu_op, out_alu_src2, out_rd_src, out_we, out_except},
            {3'd2, 2'd0, 1'b0, 1'b1, 1'b0});
        chk("add_regs", {out_rs, out_rt, out_rd}, {5'd1, 5'd2, 5'd3});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sub_count", 32'(count), 32'd1);
        chk("sub_alu_op", 32'(out_alu_op), 32'd3);
        chk("sub_rd", 32'(out_rd), 32'd6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("empty_out_valid", 32'(out_valid), 32'd0);
        chk("empty_masked_alu", 32'(out_alu_op), 32'd0);

        // ---- immediates back to back ----
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = mk_i(imm_op[i], 5'(i + 1), 5'(i + 7), imm_val[i]);
            step();
        end
        in_valid = 1'b0;
        chk("imm_full_count", 32'(count), 32'd4);
        chk("imm_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("imm_alu_op", 32'(out_alu_op), 32'(imm_alu[i]));
            chk("imm_src2", 32'(out_alu_src2), 32'(imm_src[i]));
            chk("imm_rd_src_we", {out_rd_src, out_we, out_except}, {1'b1, 1'b1, 1'b0});
            chk("imm_value", 32'(out_imm), 32'(imm_val[i]));
            chk("imm_rt", 32'(out_rt), 32'(i + 7));
            chk("imm_rs", 32'(out_rs), 32'(i + 1));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("imm_drained", 32'(count), 32'd0);

        // ---- full queue, pop-only cycle, then 3 laps of push+pop ----
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = mk_r(5'd1, 5'd1, 5'(i), 6'h24);
            step();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        in_inst   = mk_r(5'd1, 5'd1, 5'd4, 6'h24);
        out_ready = 1'b1;
        step();
        chk("full_pop_only_count", 32'(count), 32'd3);
        chk("full_pop_only_head", 32'(out_rd), 32'd1);
        chk("full_pop_only_ready", 32'(in_ready), 32'd1);
        model_q = '{5'd1, 5'd2, 5'd3};
        next_rd = 5'd4;
        for (int k = 0; k < 12; k++) begin
            in_inst = mk_r(5'd1, 5'd1, next_rd, 6'h24);
            step();
            model_q.push_back(next_rd);
            void'(model_q.pop_front());
            next_rd = next_rd + 5'd1;
            chk("lap_count", 32'(count), 32'd3);
            chk("lap_head_rd", 32'(out_rd), 32'(model_q[0]));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_head_rd", 32'(out_rd), 32'(model_q[i]));
            step();
        end
        out_ready = 1'b0;
        chk("lap_drained", 32'(count), 32'd0);

        // ---- exception handling with halt ----
        in_valid = 1'b1;
        in_inst  = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        chk("exc_pending_set", 32'(exc_pending), 32'd1);
        chk("exc_in_ready", 32'(in_ready), 32'd0);
        chk("exc_entry", {out_except, out_we, out_alu_op, out_alu_src2, out_rd_src},
            {1'b1, 1'b0, 3'd0, 2'd0, 1'b0});
        in_valid = 1'b1;
        in_inst  = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        step();
        in_valid = 1'b0;
        chk("halt_no_push", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("halt_drains", 32'(count), 32'd0);
        chk("halt_still_pending", {exc_pending, in_ready}, {1'b1, 1'b0});
        exc_clear = 1'b1;
        step();
        exc_clear = 1'b0;
        chk("exc_cleared", {exc_pending, in_ready}, {1'b0, 1'b1});
        in_valid  = 1'b1;
        exc_clear = 1'b1;
        in_inst   = 32'hFC00_0000;
        step();
        in_valid  = 1'b0;
        exc_clear = 1'b0;
        chk("set_beats_clear", 32'(exc_pending), 32'd1);
        chk("second_exc_entry", {out_except, 3'(count)}, {1'b1, 3'd1});

        // ---- async reset with 3 entries queued ----
        exc_clear = 1'b1;
        step();
        exc_clear = 1'b0;
        in_valid  = 1'b1;
        in_inst   = mk_r(5'd2, 5'd3, 5'd4, 6'h25);
        step();
        step();
        in_valid = 1'b0;
        chk("pre_reset_count", 32'(count), 32'd3);
`ifdef DECODE_STATS_EN
        chk("pre_reset_stat_decoded", 32'(stat_decoded), 32'd26);
        chk("pre_reset_stat_except", 32'(stat_except), 32'd2);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_fields", {out_alu_op, out_we, out_rd, out_imm}, 32'd0);
`ifdef DECODE_STATS_EN
        chk("async_rst_stats", {stat_decoded, stat_except}, 32'd0);
`endif
        step();
        reset_n = 1'b1;
        step();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_inst  = mk_r(5'd7, 5'd8, 5'd9, 6'h27);
        step();
        in_valid = 1'b0;
        chk("post_reset_nor", {out_alu_op, out_rd, 3'(count)}, {3'd6, 5'd9, 3'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
